// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package dmem_arbiter_pkg;

    // Encoding 2'd3 is unused; the FSM recovers from it to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } arb_state_t;

    localparam int unsigned DEF_ADDR_W        = 6;
    localparam int unsigned DEF_MAX_WAIT      = 4;
    localparam logic [3:0]  DEF_FORBID_NIBBLE = 4'h4;

    // True when a byte address falls in the region that must never reach the RAM.
    function automatic logic is_forbidden(input logic [31:0] addr, input logic [3:0] nibble);
        return (addr[31:28] == nibble);
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Shares the single-port DataRam between the CPU MEM stage and a debug/loader port.
// Latency: CPU and debug writes/grants are same-cycle; debug read data arrives one cycle after its grant.
// Backpressure: CPU has priority; a pending debug request is forced in after MAX_WAIT busy CPU cycles, stalling the pipeline for that one cycle.
//
// Ports:
//   clk, reset                   rising-edge clock, asynchronous active-low reset
//   cpu_addr/wdata/we/re         MEM-stage access; cpu_rdata is combinational load data
//   cpu_stall                    freezes the pipeline during a forced debug cycle
//   dbg_req/we/addr/wdata        debug access request, held until dbg_gnt
//   dbg_gnt                      debug owns the RAM this cycle; the access completes at this edge
//   dbg_rvalid/dbg_rdata         registered debug read result, one cycle after a read grant
//   ram_a/ram_d/ram_we/ram_spo   RAM interface (asynchronous read data in ram_spo)
//   err_forbid/err_addr          sticky flag and address of the first forbidden access
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W        = DEF_ADDR_W,
    parameter int unsigned MAX_WAIT      = DEF_MAX_WAIT,
    parameter logic [3:0]  FORBID_NIBBLE = DEF_FORBID_NIBBLE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic              cpu_we,
    input  logic              cpu_re,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [31:0]       dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [31:0]       dbg_rdata,
    output logic [ADDR_W-1:0] ram_a,
    output logic [31:0]       ram_d,
    output logic              ram_we,
    input  logic [31:0]       ram_spo,
    output logic              err_forbid,
    output logic [31:0]       err_addr
);

    localparam int unsigned        CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              gnt_raw;
    logic              stall_raw;
    logic              cpu_act;

    logic              owner_act;
    logic              owner_we;
    logic [31:0]       owner_addr;
    logic              owner_fb;

    assign cpu_act = cpu_we | cpu_re;

    // ------------------------------------------------------------------
    // Arbitration FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gnt_raw   = 1'b0;
        stall_raw = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (dbg_req) begin
                    if (!cpu_act) begin
                        // Free RAM: debug goes straight in without disturbing the CPU.
                        gnt_raw = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = CNT_ONE;
                    end
                end
            end
            ST_WAIT: begin
                if (!dbg_req) begin
                    // Requester withdrew without a grant; tolerated, just rearm.
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (!cpu_act) begin
                    gnt_raw   = 1'b1;
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = ST_FORCE;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ST_FORCE: begin
                gnt_raw   = 1'b1;
                stall_raw = 1'b1;
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Gating with reset abandons an in-flight forced access the moment reset drops.
    assign dbg_gnt   = gnt_raw & reset;
    assign cpu_stall = stall_raw & reset;

    // ------------------------------------------------------------------
    // RAM mux
    // ------------------------------------------------------------------
    assign owner_act  = dbg_gnt | cpu_act;
    assign owner_we   = dbg_gnt ? dbg_we    : cpu_we;
    assign owner_addr = dbg_gnt ? dbg_addr  : cpu_addr;
    assign ram_d      = dbg_gnt ? dbg_wdata : cpu_wdata;
    assign owner_fb   = is_forbidden(owner_addr, FORBID_NIBBLE);

    // Upper address bits are dropped, so addresses alias every 4*2^ADDR_W bytes.
    assign ram_a  = owner_addr[ADDR_W+1:2];
    assign ram_we = owner_we & ~owner_fb & reset;

    assign cpu_rdata = (reset && !dbg_gnt && !is_forbidden(cpu_addr, FORBID_NIBBLE))
                       ? ram_spo : 32'h0;

    // ------------------------------------------------------------------
    // Debug read capture and forbidden-access logging
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= 32'h0;
            err_forbid <= 1'b0;
            err_addr   <= 32'h0;
        end else begin
            dbg_rvalid <= dbg_gnt & ~dbg_we;
            if (dbg_gnt && !dbg_we) begin
                dbg_rdata <= is_forbidden(dbg_addr, FORBID_NIBBLE) ? 32'h0 : ram_spo;
            end
            // Only the first offender is recorded; later ones leave err_addr alone.
            if (owner_act && owner_fb && !err_forbid) begin
                err_forbid <= 1'b1;
                err_addr   <= owner_addr;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 64x32 asynchronous-read RAM.
// Latency: inputs change 1ns after a rising edge; outputs are checked 3ns after it.
// Backpressure: n/a (bench drives a fixed directed sequence).
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic [5:0]  ram_a;
    logic [31:0] ram_d;
    logic        ram_we;
    logic [31:0] ram_spo;
    logic        err_forbid;
    logic [31:0] err_addr;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [64];

    dmem_arbiter #(.ADDR_W(6), .MAX_WAIT(4), .FORBID_NIBBLE(4'h4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_we     (cpu_we),
        .cpu_re     (cpu_re),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .ram_a      (ram_a),
        .ram_d      (ram_d),
        .ram_we     (ram_we),
        .ram_spo    (ram_spo),
        .err_forbid (err_forbid),
        .err_addr   (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM environment: asynchronous read, synchronous write.
    assign ram_spo = mem[ram_a];
    always @(posedge clk) begin
        if (ram_we) mem[ram_a] <= ram_d;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge (input drive point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before checking (still well before the next edge).
    task automatic settle();
        #2;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        reset     = 1'b0;
        cpu_addr  = 32'h0;
        cpu_wdata = 32'h0;
        cpu_we    = 1'b0;
        cpu_re    = 1'b0;
        dbg_req   = 1'b1;
        dbg_we    = 1'b1;
        dbg_addr  = 32'h10;
        dbg_wdata = 32'h1111_1111;

        // ---------------- Reset state: outputs gated even with a request pending
        tick();
        settle();
        chk("rst_gnt",    32'(dbg_gnt),    32'h0);
        chk("rst_we",     32'(ram_we),     32'h0);
        chk("rst_stall",  32'(cpu_stall),  32'h0);
        chk("rst_rvalid", 32'(dbg_rvalid), 32'h0);
        chk("rst_rdata",  dbg_rdata,       32'h0);
        chk("rst_err",    32'(err_forbid), 32'h0);
        chk("rst_eaddr",  err_addr,        32'h0);
        dbg_req = 1'b0;
        tick();
        reset = 1'b1;

        // ---------------- 1. Idle debug write
        tick();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h10; dbg_wdata = 32'hDEAD_BEEF;
        settle();
        chk("t1_gnt",   32'(dbg_gnt),   32'h1);
        chk("t1_ram_a", 32'(ram_a),     32'h4);
        chk("t1_we",    32'(ram_we),    32'h1);
        chk("t1_d",     ram_d,          32'hDEAD_BEEF);
        chk("t1_stall", 32'(cpu_stall), 32'h0);
        tick();
        dbg_req = 1'b0; cpu_re = 1'b1; cpu_addr = 32'h10;
        settle();
        chk("t1_norv",   32'(dbg_rvalid), 32'h0);
        chk("t1_rdata",  cpu_rdata,       32'hDEAD_BEEF);
        chk("t1_stall2", 32'(cpu_stall),  32'h0);

        // ---------------- 2. Contention, forced grant after 4 WAIT cycles
        tick();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
        settle();
        chk("t2_c0_gnt",   32'(dbg_gnt),   32'h0);
        chk("t2_c0_rdata", cpu_rdata,      32'hDEAD_BEEF);
        for (int c = 1; c <= 4; c++) begin
            tick();
            settle();
            chk($sformatf("t2_c%0d_gnt", c),   32'(dbg_gnt),   32'h0);
            chk($sformatf("t2_c%0d_stall", c), 32'(cpu_stall), 32'h0);
        end
        tick();
        settle();
        chk("t2_c5_gnt",   32'(dbg_gnt),   32'h1);
        chk("t2_c5_stall", 32'(cpu_stall), 32'h1);
        chk("t2_c5_rdata", cpu_rdata,      32'h0);
        chk("t2_c5_we",    32'(ram_we),    32'h0);
        tick();
        dbg_req = 1'b0;
        settle();
        chk("t2_c6_rv",    32'(dbg_rvalid), 32'h1);
        chk("t2_c6_rd",    dbg_rdata,       32'hDEAD_BEEF);
        chk("t2_c6_stall", 32'(cpu_stall),  32'h0);
        tick();
        settle();
        chk("t2_c7_rv", 32'(dbg_rvalid), 32'h0);

        // ---------------- 3. CPU priority, debug served when CPU goes idle
        tick();
        cpu_re = 1'b0; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h1111_2222;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h24; dbg_wdata = 32'h3333_4444;
        settle();
        chk("t3_c0_gnt",   32'(dbg_gnt),   32'h0);
        chk("t3_c0_we",    32'(ram_we),    32'h1);
        chk("t3_c0_a",     32'(ram_a),     32'h8);
        chk("t3_c0_d",     ram_d,          32'h1111_2222);
        tick();
        settle();
        chk("t3_c1_gnt",   32'(dbg_gnt),   32'h0);
        chk("t3_c1_stall", 32'(cpu_stall), 32'h0);
        tick();
        cpu_we = 1'b0;
        settle();
        chk("t3_c2_gnt",   32'(dbg_gnt),   32'h1);
        chk("t3_c2_a",     32'(ram_a),     32'h9);
        chk("t3_c2_we",    32'(ram_we),    32'h1);
        chk("t3_c2_stall", 32'(cpu_stall), 32'h0);
        tick();
        dbg_req = 1'b0; cpu_re = 1'b1; cpu_addr = 32'h20;
        settle();
        chk("t3_rd20", cpu_rdata, 32'h1111_2222);
        tick();
        cpu_addr = 32'h24;
        settle();
        chk("t3_rd24", cpu_rdata, 32'h3333_4444);

        // ---------------- 4. Forbidden accesses
        tick();
        cpu_re = 1'b0; cpu_we = 1'b1; cpu_addr = 32'h0; cpu_wdata = 32'hCAFE_F00D;
        tick();
        cpu_addr = 32'h4000_0008; cpu_wdata = 32'hBAD0_BAD0;
        settle();
        chk("t4_we",    32'(ram_we),     32'h0);
        chk("t4_err0",  32'(err_forbid), 32'h0);
        tick();
        cpu_we = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h4000_0000;
        settle();
        chk("t4_err1",  32'(err_forbid), 32'h1);
        chk("t4_eaddr", err_addr,        32'h4000_0008);
        chk("t4_gnt",   32'(dbg_gnt),    32'h1);
        tick();
        dbg_req = 1'b0; cpu_re = 1'b1; cpu_addr = 32'h4000_0010;
        settle();
        chk("t4_rv",     32'(dbg_rvalid), 32'h1);
        chk("t4_rd",     dbg_rdata,       32'h0);
        chk("t4_eaddr2", err_addr,        32'h4000_0008);
        chk("t4_cpu_fb", cpu_rdata,       32'h0);
        tick();
        cpu_addr = 32'h8;
        settle();
        chk("t4_word2", cpu_rdata, 32'h0);
        tick();
        cpu_addr = 32'h0;
        settle();
        chk("t4_word0", cpu_rdata, 32'hCAFE_F00D);

        // ---------------- 5. Address aliasing
        tick();
        cpu_re = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h104; dbg_wdata = 32'h5A5A_5A5A;
        settle();
        chk("t5_gnt", 32'(dbg_gnt), 32'h1);
        chk("t5_a",   32'(ram_a),   32'h1);
        chk("t5_we",  32'(ram_we),  32'h1);
        tick();
        dbg_req = 1'b0; cpu_re = 1'b1; cpu_addr = 32'h4;
        settle();
        chk("t5_rd", cpu_rdata, 32'h5A5A_5A5A);

        // ---------------- 6. Reset during a forced debug write
        tick();
        cpu_addr = 32'h10;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h10; dbg_wdata = 32'h0123_4567;
        for (int c = 1; c <= 5; c++) tick();
        settle();
        chk("t6_force_gnt", 32'(dbg_gnt), 32'h1);
        reset = 1'b0;
        #1;
        chk("t6_we",     32'(ram_we),     32'h0);
        chk("t6_gnt",    32'(dbg_gnt),    32'h0);
        chk("t6_stall",  32'(cpu_stall),  32'h0);
        chk("t6_rdata",  cpu_rdata,       32'h0);
        chk("t6_rv",     32'(dbg_rvalid), 32'h0);
        chk("t6_err",    32'(err_forbid), 32'h0);
        chk("t6_eaddr",  err_addr,        32'h0);
        tick();
        dbg_req = 1'b0;
        reset = 1'b1;
        settle();
        chk("t6_post_stall", 32'(cpu_stall), 32'h0);
        chk("t6_post_gnt",   32'(dbg_gnt),   32'h0);
        chk("t6_post_mem",   cpu_rdata,      32'hDEAD_BEEF);
        tick();
        cpu_re = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
        settle();
        chk("t6_idle_gnt", 32'(dbg_gnt), 32'h1);
        tick();
        dbg_req = 1'b0;
        settle();
        chk("t6_idle_rd", dbg_rdata, 32'hDEAD_BEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
